br_resolve: RTL
===============

Name: br_resolve

Overview:
- EX-stage branch/jump resolution and fetch-PC control for the non-forwarding pipeline.
- Consumes br_less/br_equal from the branch comparator and drives br_unsigned back to it.
- Decides taken/not-taken under static not-taken prediction and computes the redirect target.
- Owns the fetch PC register and generates IF/ID and ID/EX flushes.
- Keeps branch statistics counters.

Parameters:
- RESET_PC, 32'h0000_0000, fetch PC after reset.
- TRAP_VEC, 32'h0000_0010, PC loaded on a misaligned jump/branch target.
- FLUSH_CYC, 1, extra IF/ID flush cycles after a redirect (covers synchronous IMEM latency); 0..3.
- CNT_W, 32, width of statistics counters.

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, asynchronous active-low reset.
- stall, input, 1, hazard-unit stall; holds PC.
- ex_valid, input, 1, EX holds a real instruction.
- ex_is_branch, input, 1, conditional branch in EX.
- ex_is_jal, input, 1, JAL in EX.
- ex_is_jalr, input, 1, JALR in EX.
- ex_funct3, input, 3, branch funct3.
- br_less, input, 1, comparator result.
- br_equal, input, 1, comparator result.
- ex_pc, input, 32, PC of EX instruction.
- ex_imm, input, 32, sign-extended immediate.
- ex_rs1_data, input, 32, rs1 value for JALR.
- br_unsigned, output, 1, comparator mode.
- pc, output, 32, current fetch PC.
- redirect, output, 1, taken redirect this cycle.
- flush_if_id, output, 1, kill IF/ID contents.
- flush_id_ex, output, 1, kill ID/EX contents.
- trap_misaligned, output, 1, one-cycle pulse on misaligned target.
- br_cnt, output, CNT_W, conditional branches resolved.
- br_taken_cnt, output, CNT_W, conditional branches taken.

Behaviour:
- Reset (async assert, sync-release usage):
  - pc=RESET_PC; redirect, flushes and trap_misaligned=0; counters=0; state=RUN.
- br_unsigned: combinational, = ex_funct3[1].
- Branch condition by funct3:
  - 000: equal; 001: !equal; 100/110: less; 101/111: !less.
  - 010/011: never taken, still counted in br_cnt.
- Target computation:
  - Branch/JAL: ex_pc+ex_imm.
  - JALR: (ex_rs1_data+ex_imm) & ~1.
  - All sums are 32-bit modulo; wrap-around is allowed.
- Taken condition: take = ex_valid & state==RUN & (jal | jalr | branch&cond). If several is_* flags are set, priority is jalr > jal > branch.
- take with target[1:0]==0:
  - redirect=1 and flush_if_id=flush_id_ex=1, combinational in the same cycle.
  - Next pc=target.
  - If FLUSH_CYC>0, go to FLUSH with counter=FLUSH_CYC.
- take with target[1]==1:
  - No redirect; trap_misaligned=1 (combinational pulse) and both flushes=1.
  - Next pc=TRAP_VEC; enter FLUSH as above.
- Otherwise:
  - stall=0: pc<=pc+4.
  - stall=1: pc holds.
- redirect/trap overrides stall; the PC still loads the target while stall=1.
- FLUSH state:
  - flush_if_id=1, flush_id_ex=0, redirect=0; ex_* inputs are ignored and not counted.
  - pc advances by 4 unless stall.
  - Counter decrements; return to RUN in the cycle it reaches 0 (FLUSH lasts exactly FLUSH_CYC cycles).
- Counters (wrap at 2^CNT_W; updated only in RUN):
  - br_cnt += 1 on ex_valid & ex_is_branch.
  - br_taken_cnt += 1 when that branch is taken, including taken misaligned branches.
- Reset mid-FLUSH: returns to RUN immediately; no residual flush.
- State encoding is internal; only RUN/FLUSH are legal, and an illegal encoding recovers to RUN.

Test Plan:
- Reset, then 4 clocks, stall=0 -> pc: 0x0, 0x4, 0x8, 0xC; all flags 0.
- BEQ ex_pc=0x100, imm=0x20, br_equal=1 -> redirect and both flushes high one cycle; next pc=0x120; next cycle flush_if_id=1 only; br_cnt=1, br_taken_cnt=1.
- BGEU funct3=111, br_less=1 -> br_unsigned=1, no redirect, pc+4; br_cnt increments, br_taken_cnt unchanged.
- JALR rs1=0x203, imm=0x0 -> target 0x202 -> trap_misaligned pulse; next pc=0x10; counters unchanged.
- JAL taken while stall=1 -> pc loads target anyway; following stalled cycle pc holds.
- Assert rst_n=0 during FLUSH -> flush_if_id drops asynchronously; pc=RESET_PC; counters 0.

Source files
------------

// File: rtl/br_resolve.sv
// EX-stage branch/jump resolution: decides taken/not-taken (static not-taken),
// owns the fetch PC, raises pipeline flushes and keeps branch statistics.
module br_resolve #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] TRAP_VEC  = 32'h0000_0010,
   parameter int          FLUSH_CYC = 1,
   parameter int          CNT_W     = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             stall,
   input  logic             ex_valid,
   input  logic             ex_is_branch,
   input  logic             ex_is_jal,
   input  logic             ex_is_jalr,
   input  logic [2:0]       ex_funct3,
   input  logic             br_less,
   input  logic             br_equal,
   input  logic [31:0]      ex_pc,
   input  logic [31:0]      ex_imm,
   input  logic [31:0]      ex_rs1_data,
   output logic             br_unsigned,
   output logic [31:0]      pc,
   output logic             redirect,
   output logic             flush_if_id,
   output logic             flush_id_ex,
   output logic             trap_misaligned,
   output logic [CNT_W-1:0] br_cnt,
   output logic [CNT_W-1:0] br_taken_cnt
);

   typedef enum logic [1:0] {
      RUN   = 2'b01,
      FLUSH = 2'b10
   } state_t;

   state_t      state, state_nxt;
   logic [1:0]  fcnt, fcnt_nxt;
   logic [31:0] pc_nxt;
   logic [31:0] target;
   logic        cond;
   logic        in_run;
   logic        take;
   logic        misaligned;
   logic        branch_taken;

   assign br_unsigned = ex_funct3[1];

   always_comb begin
      cond = 1'b0;
      case (ex_funct3)
         3'b000:          cond = br_equal;
         3'b001:          cond = ~br_equal;
         3'b100, 3'b110:  cond = br_less;
         3'b101, 3'b111:  cond = ~br_less;
         default:         cond = 1'b0;
      endcase
   end

   always_comb begin
      target = ex_pc + ex_imm;
      if (ex_is_jalr) target = (ex_rs1_data + ex_imm) & 32'hFFFF_FFFE;
   end

   assign in_run       = (state == RUN);
   assign take         = ex_valid & in_run & (ex_is_jalr | ex_is_jal | (ex_is_branch & cond));
   // Bit 0 can only be set by a malformed branch/JAL immediate; treat it as misaligned too.
   assign misaligned   = |target[1:0];
   assign branch_taken = ex_is_branch & cond & ~ex_is_jal & ~ex_is_jalr;

   assign redirect        = take & ~misaligned;
   assign trap_misaligned = take & misaligned;
   assign flush_id_ex     = take;
   assign flush_if_id     = take | (state == FLUSH);

   always_comb begin
      state_nxt = state;
      fcnt_nxt  = fcnt;
      pc_nxt    = stall ? pc : pc + 32'd4;
      case (state)
         RUN: begin
            if (take) begin
               pc_nxt = misaligned ? TRAP_VEC : target;
               if (FLUSH_CYC > 0) begin
                  state_nxt = FLUSH;
                  fcnt_nxt  = 2'(FLUSH_CYC);
               end
            end
         end
         FLUSH: begin
            if (fcnt <= 2'd1) begin
               state_nxt = RUN;
               fcnt_nxt  = 2'd0;
            end else begin
               fcnt_nxt = fcnt - 2'd1;
            end
         end
         default: begin
            state_nxt = RUN;
            fcnt_nxt  = 2'd0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= RUN;
         fcnt  <= 2'd0;
         pc    <= RESET_PC;
      end else begin
         state <= state_nxt;
         fcnt  <= fcnt_nxt;
         pc    <= pc_nxt;
      end
   end

   // Statistics only see instructions resolved in RUN; flushed slots are ignored.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         br_cnt       <= '0;
         br_taken_cnt <= '0;
      end else if (in_run && ex_valid && ex_is_branch) begin
         br_cnt <= br_cnt + CNT_W'(1);
         if (branch_taken) br_taken_cnt <= br_taken_cnt + CNT_W'(1);
      end
   end

endmodule
